execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  EX stage of the 5-stage 16-bit core. Consumes ID pipeline regs, computes ALU/address results,
//  resolves branches against the IF prediction, drives redirect to InstructionFetch, and registers
//  results into EX/MA regs. Multi-cycle iterative multiplier stalls upstream while busy.
// PARAMETERS
//  DW      16  datapath width
//  IMM_W   7   immediate width (sign-extended to DW)
//  MUL_CYC 16  multiplier iterations (one partial product per cycle)
// PORTS
//  clk               in   1   rising-edge clock
//  reset             in   1   synchronous, active-high reset
//  NPC_ID            in   16  PC+1 of the instruction in EX
//  REG1_DATA_ID      in   16  rs1 operand
//  REG2_DATA_ID      in   16  rs2 operand / store data
//  DEST_REG_INDEX_ID in   5   rd index
//  IMMEDIATE_ID      in   7   signed immediate
//  CTRL_ID           in   4   opcode (ex_pkg encoding)
//  BRANCH_PRED_ID    in   1   IF prediction carried with instruction (1=taken)
//  RES_EX            out  16  ALU result / mem address / link value
//  STORE_DATA_EX     out  16  REG2 data for SW
//  REG_EX            out  6   {wr_en, rd[4:0]}
//  CTRL_EX           out  4   opcode forwarded to MA/WB
//  TARGET            out  16  redirect PC
//  TARGET_EN         out  1   redirect strobe, 1-cycle pulse
//  MISPRED           out  1   1-cycle pulse: IF/ID flush wrong-path work
//  STALL_EX          out  1   1 = upstream holds IF/ID regs and PC
// BEHAVIOUR
//  Reset: all outputs 0 (CTRL_EX=NOP, REG_EX=0, STALL_EX=0); FSM->IDLE; any MUL in flight dropped.
//  Opcodes: 0 NOP,1 ADD,2 SUB,3 AND,4 OR,5 XOR,6 SLL,7 SRL,8 ADDI,9 LW,10 SW,11 BEQ,12 BNE,
//   13 JAL,14 MUL,15 reserved (treated as NOP).
//  Non-MUL ops: 1-cycle latency, outputs registered on the edge after inputs are presented.
//  Arithmetic mod 2^16, no flags. SLL/SRL shift by REG2[3:0]; SRL logical. imm = sext(IMMEDIATE_ID).
//  LW/SW: RES_EX = REG1 + imm. SW and branches: REG_EX[5]=0. JAL: RES_EX = NPC_ID, always taken.
//  REG_EX[5] forced 0 when rd==0 (r0 never written).
//  Branch: taken = BEQ ? (R1==R2) : BNE ? (R1!=R2) : JAL; tgt = NPC_ID + imm.
//   If taken != BRANCH_PRED_ID: registered MISPRED=1, TARGET_EN=1,
//   TARGET = taken ? tgt : NPC_ID. Otherwise both 0, TARGET holds last value.
//  Squash: in the cycle after MISPRED=1, the instruction presented is wrong-path; EX registers a
//   bubble (CTRL_EX=NOP, REG_EX=0) and may not raise TARGET_EN/MISPRED or start MUL for it.
//  MUL FSM: IDLE -(CTRL_ID==MUL, not squashed)-> BUSY -(cnt==MUL_CYC-1)-> DONE -> IDLE.
//   IDLE: STALL_EX combinationally 1 when MUL is presented. BUSY: STALL_EX=1; shift-add 1 bit/cycle;
//   cnt 0..MUL_CYC-1; EX/MA outputs are bubbles. DONE: STALL_EX=0; RES_EX = low 16 of product,
//   REG_EX/CTRL_EX from latched MUL; upstream advances on this edge.
//   Total MUL occupancy MUL_CYC+1 cycles; operands latched on entry (input changes ignored).
//  Back-to-back MULs: DONE->IDLE then new MUL restarts immediately (no extra bubble).
//  reset during BUSY: FSM IDLE, STALL_EX=0 next cycle, product discarded.
// CONFIGURATION
//  EX_MUL_EN defined: MUL as above. Undefined: no FSM/multiplier; opcode 14 executes as NOP
//   (REG_EX=0, RES_EX=0), STALL_EX tied 0.
// STRUCTURE
//  ex_pkg: opcode localparams, REG_EX field positions, DW/IMM_W defaults, sext helper function.
//  One sub-module: ex_iter_mul (start/busy/done handshake, operand latch, shift-add datapath),
//   instantiated only under EX_MUL_EN. ALU and branch compare stay inline.
// TESTING
//  ADD R1=0x7FFF,R2=0x0001,rd=3 -> next cycle RES_EX=0x8000, REG_EX=6'b1_00011, CTRL_EX=1.
//  ADDI rd=0 R1=5 imm=7'h7F -> RES_EX=0x0004, REG_EX[5]=0.
//  BEQ R1=R2, NPC=0x0010, imm=-4, pred=0 -> MISPRED=1, TARGET_EN=1, TARGET=0x000C for 1 cycle;
//   next instr (ADD rd=2) squashed to bubble. Same with pred=1 -> no pulses.
//  BNE R1=R2, pred=1, NPC=0x0020 -> MISPRED=1, TARGET=0x0020.
//  MUL 0x0123*0x0045 (EX_MUL_EN) -> STALL_EX high 16 cycles, then RES_EX=0x4E6F; reset at cycle 8 ->
//   STALL_EX=0, no result written. Without EX_MUL_EN -> STALL_EX never 1, REG_EX=0.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared constants and helpers for the EX stage of the 16-bit core.
//   - datapath / immediate widths and multiplier iteration count
//   - opcode encoding (CTRL_ID / CTRL_EX)
//   - REG_EX field layout {wr_en, rd[4:0]}
//   - multiplier FSM state encoding
//   - sext(): sign-extend an immediate to the datapath width
package ex_pkg;

    localparam int DW      = 16;
    localparam int IMM_W   = 7;
    localparam int MUL_CYC = 16;
    localparam int CNT_W   = $clog2(MUL_CYC);

    localparam int OP_W       = 4;
    localparam int RD_W       = 5;
    localparam int REG_W      = RD_W + 1;
    localparam int REG_WE_BIT = RD_W;

    localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd2;
    localparam logic [OP_W-1:0] OP_AND  = 4'd3;
    localparam logic [OP_W-1:0] OP_OR   = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd6;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd7;
    localparam logic [OP_W-1:0] OP_ADDI = 4'd8;
    localparam logic [OP_W-1:0] OP_LW   = 4'd9;
    localparam logic [OP_W-1:0] OP_SW   = 4'd10;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'd11;
    localparam logic [OP_W-1:0] OP_BNE  = 4'd12;
    localparam logic [OP_W-1:0] OP_JAL  = 4'd13;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd14;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    function automatic logic [DW-1:0] sext(input logic [IMM_W-1:0] imm);
        return {{(DW-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/ex_iter_mul.sv
// ex_iter_mul: iterative shift-add multiplier, one partial product per cycle.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : accept operands a/b and tag (only honoured in IDLE)
//   a, b       : multiplicand / multiplier
//   tag_in     : destination descriptor carried alongside the operation
//   busy       : iterating (upstream must stall)
//   done       : one cycle, product/tag valid
//   product    : low DW bits of a*b
//   tag        : tag latched at start
// The start edge already folds in partial product 0 from the live operands,
// so BUSY covers iterations 1..MUL_CYC-1 and the unit is occupied for
// MUL_CYC+1 cycles counting the presentation cycle and DONE.
module ex_iter_mul
    import ex_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic [REG_W-1:0] tag_in,
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    product,
    output logic [REG_W-1:0] tag
);

    mul_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    acc, mcand, mplier;

    always_ff @(posedge clk) begin
        if (reset) state <= MUL_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MUL_IDLE: if (start) state_nxt = MUL_BUSY;
            MUL_BUSY: if (cnt == CNT_W'(MUL_CYC-1)) state_nxt = MUL_DONE;
            MUL_DONE: state_nxt = MUL_IDLE;
            default:  state_nxt = MUL_IDLE;
        endcase
    end

    assign busy    = (state == MUL_BUSY);
    assign done    = (state == MUL_DONE);
    assign product = acc;

    // cnt names the multiplier bit consumed on the coming edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            tag    <= '0;
        end else if (state == MUL_IDLE && start) begin
            acc    <= b[0] ? a : '0;
            mcand  <= a << 1;
            mplier <= b >> 1;
            cnt    <= CNT_W'(1);
            tag    <= tag_in;
        end else if (busy) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage 16-bit core.
//   Computes ALU / address / link results, resolves branches against the
//   IF prediction and registers everything into the EX/MA outputs.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   NPC_ID ..BRANCH_PRED_ID  ID pipeline registers (operands, rd, imm, opcode, prediction)
//   RES_EX, STORE_DATA_EX    result / address, store data
//   REG_EX, CTRL_EX          {wr_en, rd}, forwarded opcode
//   TARGET, TARGET_EN        redirect PC and its 1-cycle strobe
//   MISPRED                  1-cycle flush pulse for IF/ID
//   STALL_EX                 upstream hold while the multiplier owns EX
// Configuration: define EX_MUL_EN to build the iterative multiplier (opcode 14).
//   Without it opcode 14 behaves as NOP and STALL_EX is tied low.
module execute_stage
    import ex_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [DW-1:0]    NPC_ID,
    input  logic [DW-1:0]    REG1_DATA_ID,
    input  logic [DW-1:0]    REG2_DATA_ID,
    input  logic [RD_W-1:0]  DEST_REG_INDEX_ID,
    input  logic [IMM_W-1:0] IMMEDIATE_ID,
    input  logic [OP_W-1:0]  CTRL_ID,
    input  logic             BRANCH_PRED_ID,
    output logic [DW-1:0]    RES_EX,
    output logic [DW-1:0]    STORE_DATA_EX,
    output logic [REG_W-1:0] REG_EX,
    output logic [OP_W-1:0]  CTRL_EX,
    output logic [DW-1:0]    TARGET,
    output logic             TARGET_EN,
    output logic             MISPRED,
    output logic             STALL_EX
);

    logic [DW-1:0]    imm, tgt;
    logic [DW-1:0]    res_nxt;
    logic [OP_W-1:0]  ctrl_nxt;
    logic [REG_W-1:0] reg_nxt;
    logic             wr_nxt, is_br, taken, squash;

    logic             mul_start, mul_busy, mul_done;
    logic [DW-1:0]    mul_product;
    logic [REG_W-1:0] mul_tag;

    // The instruction following a registered mispredict is wrong-path.
    assign squash = MISPRED;
    assign imm    = sext(IMMEDIATE_ID);
    assign tgt    = NPC_ID + imm;

    always_comb begin
        res_nxt  = '0;
        wr_nxt   = 1'b0;
        ctrl_nxt = CTRL_ID;
        is_br    = 1'b0;
        taken    = 1'b0;
        case (CTRL_ID)
            OP_ADD:  begin res_nxt = REG1_DATA_ID + REG2_DATA_ID;       wr_nxt = 1'b1; end
            OP_SUB:  begin res_nxt = REG1_DATA_ID - REG2_DATA_ID;       wr_nxt = 1'b1; end
            OP_AND:  begin res_nxt = REG1_DATA_ID & REG2_DATA_ID;       wr_nxt = 1'b1; end
            OP_OR:   begin res_nxt = REG1_DATA_ID | REG2_DATA_ID;       wr_nxt = 1'b1; end
            OP_XOR:  begin res_nxt = REG1_DATA_ID ^ REG2_DATA_ID;       wr_nxt = 1'b1; end
            OP_SLL:  begin res_nxt = REG1_DATA_ID << REG2_DATA_ID[3:0]; wr_nxt = 1'b1; end
            OP_SRL:  begin res_nxt = REG1_DATA_ID >> REG2_DATA_ID[3:0]; wr_nxt = 1'b1; end
            OP_ADDI: begin res_nxt = REG1_DATA_ID + imm;                wr_nxt = 1'b1; end
            OP_LW:   begin res_nxt = REG1_DATA_ID + imm;                wr_nxt = 1'b1; end
            OP_SW:   res_nxt = REG1_DATA_ID + imm;
            OP_BEQ:  begin is_br = 1'b1; taken = (REG1_DATA_ID == REG2_DATA_ID); end
            OP_BNE:  begin is_br = 1'b1; taken = (REG1_DATA_ID != REG2_DATA_ID); end
            OP_JAL:  begin is_br = 1'b1; taken = 1'b1; res_nxt = NPC_ID; wr_nxt = 1'b1; end
            // NOP, reserved, and MUL (which only reaches here when not built
            // or via the multiplier path) all leave a clean bubble.
            default: ctrl_nxt = OP_NOP;
        endcase
        if (ctrl_nxt == OP_NOP) reg_nxt = '0;
        else                    reg_nxt = {wr_nxt && (DEST_REG_INDEX_ID != '0), DEST_REG_INDEX_ID};
    end

`ifdef EX_MUL_EN
    // Start only from idle: in DONE the finished MUL is still presented.
    assign mul_start = !mul_busy && !mul_done && !squash && (CTRL_ID == OP_MUL);

    ex_iter_mul u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (REG1_DATA_ID),
        .b       (REG2_DATA_ID),
        .tag_in  ({DEST_REG_INDEX_ID != '0, DEST_REG_INDEX_ID}),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product),
        .tag     (mul_tag)
    );
`else
    assign mul_start   = 1'b0;
    assign mul_busy    = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
    assign mul_tag     = '0;
`endif

    assign STALL_EX = mul_start | mul_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            RES_EX        <= '0;
            STORE_DATA_EX <= '0;
            REG_EX        <= '0;
            CTRL_EX       <= OP_NOP;
            TARGET        <= '0;
            TARGET_EN     <= 1'b0;
            MISPRED       <= 1'b0;
        end else begin
            TARGET_EN <= 1'b0;
            MISPRED   <= 1'b0;
            if (mul_done) begin
                RES_EX        <= mul_product;
                STORE_DATA_EX <= '0;
                REG_EX        <= mul_tag;
                CTRL_EX       <= OP_MUL;
            end else if (squash || STALL_EX) begin
                RES_EX        <= '0;
                STORE_DATA_EX <= '0;
                REG_EX        <= '0;
                CTRL_EX       <= OP_NOP;
            end else begin
                RES_EX        <= res_nxt;
                STORE_DATA_EX <= (CTRL_ID == OP_SW) ? REG2_DATA_ID : '0;
                REG_EX        <= reg_nxt;
                CTRL_EX       <= ctrl_nxt;
                if (is_br && (taken != BRANCH_PRED_ID)) begin
                    MISPRED   <= 1'b1;
                    TARGET_EN <= 1'b1;
                    TARGET    <= taken ? tgt : NPC_ID;
                end
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed self-checking bench for execute_stage.
// Multiplier scenarios follow EX_MUL_EN the same way the design does.
module tb_execute_stage;
    import ex_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic [15:0]      npc, r1, r2;
    logic [4:0]       rd;
    logic [6:0]       immv;
    logic [3:0]       op;
    logic             pred;
    logic [15:0]      res_ex, store_ex, target;
    logic [5:0]       reg_ex;
    logic [3:0]       ctrl_ex;
    logic             target_en, mispred, stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk               (clk),
        .reset             (reset),
        .NPC_ID            (npc),
        .REG1_DATA_ID      (r1),
        .REG2_DATA_ID      (r2),
        .DEST_REG_INDEX_ID (rd),
        .IMMEDIATE_ID      (immv),
        .CTRL_ID           (op),
        .BRANCH_PRED_ID    (pred),
        .RES_EX            (res_ex),
        .STORE_DATA_EX     (store_ex),
        .REG_EX            (reg_ex),
        .CTRL_EX           (ctrl_ex),
        .TARGET            (target),
        .TARGET_EN         (target_en),
        .MISPRED           (mispred),
        .STALL_EX          (stall)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] r1, r2;
        logic [4:0]  rd;
        logic [6:0]  imm;
        logic [15:0] res;
        logic [15:0] st;
        logic [5:0]  rg;
        logic [3:0]  ct;
    } vec_t;

    vec_t vt[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] d, input logic [6:0] i, input logic [15:0] n,
                         input logic p);
        op = o; r1 = a; r2 = b; rd = d; immv = i; npc = n; pred = p;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(OP_NOP, 16'h0, 16'h0, 5'd0, 7'h0, 16'h0, 1'b0);
        step(); step();
        checks++; if (res_ex !== 16'h0) begin errors++; $display("FAIL reset_res got %h exp 0000", res_ex); end
        checks++; if (reg_ex !== 6'h0) begin errors++; $display("FAIL reset_reg got %b exp 000000", reg_ex); end
        checks++; if (ctrl_ex !== 4'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", ctrl_ex); end
        checks++; if ({target_en, mispred, stall} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {target_en, mispred, stall}); end
        checks++; if (target !== 16'h0 || store_ex !== 16'h0) begin errors++; $display("FAIL reset_tgt_st got %h/%h exp 0000/0000", target, store_ex); end
        reset = 1'b0;
    endtask

    task automatic test_alu();
        vt[0]  = '{OP_ADD,  16'h7FFF, 16'h0001, 5'd3, 7'h00, 16'h8000, 16'h0000, 6'b100011, 4'd1};
        vt[1]  = '{OP_SUB,  16'h0005, 16'h0007, 5'd4, 7'h00, 16'hFFFE, 16'h0000, 6'b100100, 4'd2};
        vt[2]  = '{OP_AND,  16'hF0F0, 16'h0FF0, 5'd5, 7'h00, 16'h00F0, 16'h0000, 6'b100101, 4'd3};
        vt[3]  = '{OP_OR,   16'hF000, 16'h000F, 5'd6, 7'h00, 16'hF00F, 16'h0000, 6'b100110, 4'd4};
        vt[4]  = '{OP_XOR,  16'hFFFF, 16'h00FF, 5'd7, 7'h00, 16'hFF00, 16'h0000, 6'b100111, 4'd5};
        vt[5]  = '{OP_SLL,  16'h0001, 16'h0013, 5'd8, 7'h00, 16'h0008, 16'h0000, 6'b101000, 4'd6};
        vt[6]  = '{OP_SRL,  16'h8000, 16'h000F, 5'd9, 7'h00, 16'h0001, 16'h0000, 6'b101001, 4'd7};
        vt[7]  = '{OP_ADDI, 16'h0005, 16'h0000, 5'd0, 7'h7F, 16'h0004, 16'h0000, 6'b000000, 4'd8};
        vt[8]  = '{OP_LW,   16'h0100, 16'h0000, 5'd7, 7'h3F, 16'h013F, 16'h0000, 6'b100111, 4'd9};
        vt[9]  = '{OP_SW,   16'h0200, 16'hBEEF, 5'd0, 7'h40, 16'h01C0, 16'hBEEF, 6'b000000, 4'd10};
        vt[10] = '{4'd15,   16'h1234, 16'h5678, 5'd3, 7'h11, 16'h0000, 16'h0000, 6'b000000, 4'd0};
        for (int k = 0; k < 11; k++) begin
            drive(vt[k].op, vt[k].r1, vt[k].r2, vt[k].rd, vt[k].imm, 16'h0040, 1'b0);
            step();
            checks++; if (res_ex !== vt[k].res) begin errors++; $display("FAIL alu%0d_res got %h exp %h", k, res_ex, vt[k].res); end
            checks++; if (reg_ex !== vt[k].rg) begin errors++; $display("FAIL alu%0d_reg got %b exp %b", k, reg_ex, vt[k].rg); end
            checks++; if (ctrl_ex !== vt[k].ct) begin errors++; $display("FAIL alu%0d_ctrl got %h exp %h", k, ctrl_ex, vt[k].ct); end
            checks++; if (store_ex !== vt[k].st) begin errors++; $display("FAIL alu%0d_store got %h exp %h", k, store_ex, vt[k].st); end
            checks++; if ({mispred, target_en} !== 2'b00) begin errors++; $display("FAIL alu%0d_nopulse got %b exp 00", k, {mispred, target_en}); end
        end
    endtask

    task automatic test_branch();
        // BEQ taken, predicted not-taken: redirect to NPC-4
        drive(OP_BEQ, 16'h0009, 16'h0009, 5'd0, 7'h7C, 16'h0010, 1'b0);
        step();
        checks++; if ({mispred, target_en} !== 2'b11) begin errors++; $display("FAIL beq_pulse got %b exp 11", {mispred, target_en}); end
        checks++; if (target !== 16'h000C) begin errors++; $display("FAIL beq_target got %h exp 000c", target); end
        checks++; if (reg_ex[5] !== 1'b0) begin errors++; $display("FAIL beq_we got %b exp 0", reg_ex[5]); end
        // wrong-path ADD is squashed
        drive(OP_ADD, 16'h0001, 16'h0001, 5'd2, 7'h00, 16'h0011, 1'b0);
        step();
        checks++; if ({ctrl_ex, reg_ex} !== 10'h0) begin errors++; $display("FAIL squash_bubble got %h/%b exp 0/000000", ctrl_ex, reg_ex); end
        checks++; if ({mispred, target_en} !== 2'b00) begin errors++; $display("FAIL squash_pulse got %b exp 00", {mispred, target_en}); end
        // same BEQ, correctly predicted: no pulses, TARGET holds
        drive(OP_BEQ, 16'h0009, 16'h0009, 5'd0, 7'h7C, 16'h0010, 1'b1);
        step();
        checks++; if ({mispred, target_en} !== 2'b00) begin errors++; $display("FAIL beq_ok_pulse got %b exp 00", {mispred, target_en}); end
        checks++; if (target !== 16'h000C) begin errors++; $display("FAIL beq_ok_hold got %h exp 000c", target); end
        checks++; if (ctrl_ex !== OP_BEQ) begin errors++; $display("FAIL beq_ok_ctrl got %h exp b", ctrl_ex); end
        // following ADD proceeds normally
        drive(OP_ADD, 16'h0001, 16'h0001, 5'd2, 7'h00, 16'h0011, 1'b0);
        step();
        checks++; if (res_ex !== 16'h0002 || reg_ex !== 6'b100010) begin errors++; $display("FAIL post_beq_add got %h/%b exp 0002/100010", res_ex, reg_ex); end
        // BNE not taken, predicted taken: redirect to fall-through
        drive(OP_BNE, 16'h0033, 16'h0033, 5'd0, 7'h05, 16'h0020, 1'b1);
        step();
        checks++; if ({mispred, target_en} !== 2'b11 || target !== 16'h0020) begin errors++; $display("FAIL bne_redirect got %b %h exp 11 0020", {mispred, target_en}, target); end
        drive(OP_NOP, 16'h0, 16'h0, 5'd0, 7'h0, 16'h0021, 1'b0);
        step();
        // JAL always taken, predicted not-taken
        drive(OP_JAL, 16'h0, 16'h0, 5'd1, 7'h05, 16'h0030, 1'b0);
        step();
        checks++; if ({mispred, target_en} !== 2'b11 || target !== 16'h0035) begin errors++; $display("FAIL jal_redirect got %b %h exp 11 0035", {mispred, target_en}, target); end
        checks++; if (res_ex !== 16'h0030 || reg_ex !== 6'b100001) begin errors++; $display("FAIL jal_link got %h/%b exp 0030/100001", res_ex, reg_ex); end
        // a mispredicting branch on the wrong path must not redirect
        drive(OP_BEQ, 16'h0004, 16'h0004, 5'd0, 7'h02, 16'h0031, 1'b0);
        step();
        checks++; if ({mispred, target_en} !== 2'b00 || target !== 16'h0035) begin errors++; $display("FAIL squash_br got %b %h exp 00 0035", {mispred, target_en}, target); end
        checks++; if (ctrl_ex !== OP_NOP) begin errors++; $display("FAIL squash_br_ctrl got %h exp 0", ctrl_ex); end
        drive(OP_NOP, 16'h0, 16'h0, 5'd0, 7'h0, 16'h0, 1'b0);
        step();
    endtask

`ifdef EX_MUL_EN
    task automatic test_mul();
        int n;
        drive(OP_MUL, 16'h0123, 16'h0045, 5'd5, 7'h0, 16'h0050, 1'b0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mul_stall_comb got %b exp 1", stall); end
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            step();
            r1 = 16'hFFFF; r2 = 16'hFFFF;   // operands were latched on entry
            if (stall === 1'b1 && reg_ex !== 6'h0) begin checks++; errors++; $display("FAIL mul_busy_bubble got %b exp 000000", reg_ex); end
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL mul_stall_len got %0d exp 16", n); end
        step();
        checks++; if (res_ex !== 16'h4E6F || reg_ex !== 6'b100101 || ctrl_ex !== OP_MUL) begin errors++; $display("FAIL mul_result got %h/%b/%h exp 4e6f/100101/e", res_ex, reg_ex, ctrl_ex); end
    endtask

    task automatic test_back_to_back();
        int n;
        drive(OP_MUL, 16'h0003, 16'h0005, 5'd6, 7'h0, 16'h0, 1'b0);
        for (int m = 0; m < 2; m++) begin
            #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b%0d_start got %b exp 1", m, stall); end
            n = 0;
            while (stall === 1'b1 && n < 40) begin n++; step(); end
            checks++; if (n !== 16) begin errors++; $display("FAIL b2b%0d_len got %0d exp 16", m, n); end
            step();
            if (m == 0) begin
                checks++; if (res_ex !== 16'd15 || reg_ex !== 6'b100110) begin errors++; $display("FAIL b2b0_res got %h/%b exp 000f/100110", res_ex, reg_ex); end
                drive(OP_MUL, 16'h0007, 16'h0009, 5'd0, 7'h0, 16'h0, 1'b0);
            end else begin
                checks++; if (res_ex !== 16'd63 || reg_ex !== 6'b000000 || ctrl_ex !== OP_MUL) begin errors++; $display("FAIL b2b1_res got %h/%b/%h exp 003f/000000/e", res_ex, reg_ex, ctrl_ex); end
            end
        end
        drive(OP_NOP, 16'h0, 16'h0, 5'd0, 7'h0, 16'h0, 1'b0);
        step();
    endtask

    task automatic test_mul_reset();
        drive(OP_MUL, 16'h0123, 16'h0045, 5'd5, 7'h0, 16'h0, 1'b0);
        for (int c = 0; c < 8; c++) step();
        reset = 1'b1;
        op = OP_NOP;
        step();
        reset = 1'b0;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mulrst_stall got %b exp 0", stall); end
        for (int c = 0; c < 20; c++) begin
            step();
            checks++; if (reg_ex !== 6'h0 || ctrl_ex !== OP_NOP || stall !== 1'b0) begin errors++; $display("FAIL mulrst_quiet%0d got %b/%h/%b exp 000000/0/0", c, reg_ex, ctrl_ex, stall); end
        end
    endtask
`else
    task automatic test_mul();
        drive(OP_MUL, 16'h0123, 16'h0045, 5'd5, 7'h0, 16'h0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nomul_stall%0d got %b exp 0", c, stall); end
            step();
            checks++; if (reg_ex !== 6'h0 || res_ex !== 16'h0) begin errors++; $display("FAIL nomul_nop%0d got %b/%h exp 000000/0000", c, reg_ex, res_ex); end
        end
        drive(OP_NOP, 16'h0, 16'h0, 5'd0, 7'h0, 16'h0, 1'b0);
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mul();
`ifdef EX_MUL_EN
        test_back_to_back();
        test_mul_reset();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
